mult_share_arb: RTL and testbench

Time-shares one combinational signed N×M multiplier (`mult_NMbit`) among R requesters. Each requester presents operands with a valid/ready handshake. A round-robin arbiter picks one request, its operands are registered, the product is computed and registered, and the product is held on a single result port tagged with the requester id until the consumer accepts it. The block sits between several datapath clients and the shared multiplier, so only one multiplier instance is needed.

---
 rtl/mult_share_arb_pkg.sv | 32 +++
 rtl/mult_share_arb_if.sv | 31 +++
 rtl/mult_NMbit.sv | 22 ++
 rtl/rr_arbiter.sv | 24 ++
 rtl/mult_share_arb.sv | 98 +++++++++
 tb/tb_mult_share_arb.sv | 290 +++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mult_share_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter.
//   mult_arb_state_t : FSM state encoding (IDLE, MUL, HOLD)
//   rr_pick()        : rotating-priority search, returns the granted index or -1
package mult_arb_pkg;

    // Upper bound on the requester count handled by rr_pick().
    localparam int unsigned MaxR  = 32;
    localparam int unsigned MaxRW = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        HOLD = 2'd2
    } mult_arb_state_t;

    // Scan req starting at ptr, wrapping modulo r; first set bit wins.
    function automatic int rr_pick(input logic [MaxR-1:0] req,
                                   input int unsigned     r,
                                   input int unsigned     ptr);
        int          pick;
        int unsigned idx;
        pick = -1;
        for (int unsigned k = 0; k < MaxR; k++) begin
            idx = (ptr + k) % r;
            if (k < r && pick < 0 && req[idx[MaxRW-1:0]]) begin
                pick = int'(idx);
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mult_share_arb_if.sv
// Requester and result bus of mult_share_arb.
//   req_valid/req_ready/req_a/req_b : per-requester operand handshake
//   res_valid/res_ready/res_prod/res_id : single shared result port
// master = clients + consumer side, slave = the arbiter.
interface mult_share_arb_if #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 5,
    parameter int unsigned R = 4
);
    localparam int unsigned IDW = $clog2(R);

    logic [R-1:0]        req_valid;
    logic [R-1:0]        req_ready;
    logic [R-1:0][N-1:0] req_a;
    logic [R-1:0][M-1:0] req_b;
    logic                res_valid;
    logic                res_ready;
    logic [N+M-1:0]      res_prod;
    logic [IDW-1:0]      res_id;

    modport master (
        output req_valid, req_a, req_b, res_ready,
        input  req_ready, res_valid, res_prod, res_id
    );

    modport slave (
        input  req_valid, req_a, req_b, res_ready,
        output req_ready, res_valid, res_prod, res_id
    );

endinterface

// File: rtl/mult_NMbit.sv
// Combinational signed N x M multiplier.
//   i_a    : N-bit two's complement operand
//   i_b    : M-bit two's complement operand
//   o_prod : exact N+M-bit signed product
module mult_NMbit #(
    parameter int unsigned N = 4,
    parameter int unsigned M = 5
) (
    input  logic [N-1:0]   i_a,
    input  logic [M-1:0]   i_b,
    output logic [N+M-1:0] o_prod
);

    logic signed [N+M-1:0] w_a_ext;
    logic signed [N+M-1:0] w_b_ext;

    assign w_a_ext = {{M{i_a[N-1]}}, i_a};
    assign w_b_ext = {{N{i_b[M-1]}}, i_b};
    // N+M bits always hold the product of an N-bit and an M-bit signed value.
    assign o_prod  = w_a_ext * w_b_ext;

endmodule

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority arbiter.
//   req     : request vector
//   ptr     : index with highest priority this cycle
//   gnt     : one-hot grant (all-zero when nothing requests)
//   gnt_idx : binary index of the granted requester (0 when none)
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned R   = 4,
    parameter int unsigned IDW = $clog2(R)
) (
    input  logic [R-1:0]   req,
    input  logic [IDW-1:0] ptr,
    output logic [R-1:0]   gnt,
    output logic [IDW-1:0] gnt_idx
);

    int w_pick;

    assign w_pick  = rr_pick(MaxR'(req), R, 32'(ptr));
    assign gnt     = (w_pick >= 0) ? (R'(1) << w_pick) : '0;
    assign gnt_idx = (w_pick >= 0) ? IDW'(w_pick) : '0;

endmodule

// File: rtl/mult_share_arb.sv
// Time-shares one signed multiplier among R requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of mult_share_arb_if (operand handshakes in,
//                tagged product out)
// Flow: IDLE grants one requester and latches its operands, MUL registers
// the product, HOLD presents it until the consumer takes it.
module mult_share_arb
    import mult_arb_pkg::*;
#(
    parameter int unsigned N = 4,
    parameter int unsigned M = 5,
    parameter int unsigned R = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_share_arb_if.slave   bus
);

    localparam int unsigned IDW = $clog2(R);

    mult_arb_state_t r_state;
    mult_arb_state_t w_state_nxt;
    logic [IDW-1:0]  r_ptr;
    logic [IDW-1:0]  w_ptr_nxt;
    logic [N-1:0]    r_op_a;
    logic [M-1:0]    r_op_b;
    logic [IDW-1:0]  r_op_id;
    logic [N+M-1:0]  r_res_prod;
    logic [IDW-1:0]  r_res_id;

    logic [R-1:0]    w_gnt;
    logic [IDW-1:0]  w_gnt_idx;
    logic            w_fire;
    logic [N+M-1:0]  w_prod;

    rr_arbiter #(
        .R   (R),
        .IDW (IDW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (r_ptr),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx)
    );

    mult_NMbit #(
        .N (N),
        .M (M)
    ) u_mult (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .o_prod (w_prod)
    );

    // A grant only exists for a valid requester, so any grant in IDLE is a transfer.
    assign w_fire    = (r_state == IDLE) && (|w_gnt);
    assign w_ptr_nxt = (w_gnt_idx == IDW'(R - 1)) ? '0 : w_gnt_idx + IDW'(1);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_fire) w_state_nxt = MUL;
            MUL:     w_state_nxt = HOLD;
            HOLD:    if (bus.res_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_op_id    <= '0;
            r_res_prod <= '0;
            r_res_id   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_fire) begin
                r_op_a  <= bus.req_a[w_gnt_idx];
                r_op_b  <= bus.req_b[w_gnt_idx];
                r_op_id <= w_gnt_idx;
                r_ptr   <= w_ptr_nxt;
            end
            if (r_state == MUL) begin
                r_res_prod <= w_prod;
                r_res_id   <= r_op_id;
            end
        end
    end

    assign bus.req_ready = (r_state == IDLE) ? w_gnt : '0;
    assign bus.res_valid = (r_state == HOLD);
    assign bus.res_prod  = r_res_prod;
    assign bus.res_id    = r_res_id;

endmodule

// File: tb/tb_mult_share_arb.sv
module tb_mult_share_arb;

    localparam int N = 4;
    localparam int M = 5;
    localparam int R = 4;
    localparam int P = N + M;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;

    mult_share_arb_if #(.N(N), .M(M), .R(R)) bus ();

    mult_share_arb #(.N(N), .M(M), .R(R)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int           id;
        logic [N-1:0] a;
        logic [M-1:0] b;
        logic [P-1:0] exp_prod;
    } vec_t;

    typedef struct {
        int           id;
        logic [P-1:0] prod;
    } res_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    function automatic logic [P-1:0] ref_mul(input logic [N-1:0] a, input logic [M-1:0] b);
        int sa;
        int sb;
        int p;
        sa = $signed(a);
        sb = $signed(b);
        p  = sa * sb;
        return p[P-1:0];
    endfunction

    function automatic int ref_pick(input logic [R-1:0] v, input int ptr);
        for (int k = 0; k < R; k++) begin
            if (v[(ptr + k) % R]) return (ptr + k) % R;
        end
        return -1;
    endfunction

    task automatic idle_inputs();
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.res_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        #1;
        check("rst_res_valid", 32'(bus.res_valid), 32'd0);
        check("rst_res_prod", 32'(bus.res_prod), 32'd0);
        check("rst_res_id", 32'(bus.res_id), 32'd0);
        check("rst_req_ready_none", 32'(bus.req_ready), 32'd0);
        bus.req_valid = 4'b0010;
        #1;
        check("rst_req_ready_arb", 32'(bus.req_ready), 32'b0010);
        bus.req_valid = '0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic drain();
        bus.req_valid = '0;
        bus.res_ready = 1'b1;
        repeat (4) tick();
        bus.res_ready = 1'b0;
    endtask

    vec_t vecs[6];
    res_t exp_q[$];

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b1;
        idle_inputs();
        #2;
        do_reset();

        // Single-request vectors: grant same cycle, result two edges later.
        vecs[0] = '{id: 2, a: 4'b0011, b: 5'b00010, exp_prod: 9'd6};
        vecs[1] = '{id: 1, a: 4'b1011, b: 5'b11011, exp_prod: 9'd25};
        vecs[2] = '{id: 1, a: 4'b1111, b: 5'b00001, exp_prod: 9'h1FF};
        vecs[3] = '{id: 0, a: 4'b1000, b: 5'b10000, exp_prod: 9'h080};
        vecs[4] = '{id: 3, a: 4'b0111, b: 5'b01111, exp_prod: 9'd105};
        vecs[5] = '{id: 2, a: 4'b1000, b: 5'b01111, exp_prod: 9'h188};
        foreach (vecs[i]) begin
            bus.req_valid = 4'(1) << vecs[i].id;
            bus.req_a[vecs[i].id] = vecs[i].a;
            bus.req_b[vecs[i].id] = vecs[i].b;
            bus.res_ready = 1'b1;
            samp();
            check("vec_grant", 32'(bus.req_ready), 32'(4'(1) << vecs[i].id));
            tick();
            bus.req_valid = '0;
            samp();
            check("vec_mul_no_valid", 32'(bus.res_valid), 32'd0);
            tick();
            samp();
            check("vec_res_valid", 32'(bus.res_valid), 32'd1);
            check("vec_res_prod", 32'(bus.res_prod), 32'(vecs[i].exp_prod));
            check("vec_res_id", 32'(bus.res_id), 32'(vecs[i].id));
            tick();
        end

        // All four valid after reset: strict rotation, one result per 3 cycles.
        do_reset();
        bus.req_valid = 4'b1111;
        for (int i = 0; i < R; i++) begin
            bus.req_a[i] = 4'b1111;
            bus.req_b[i] = 5'b11111;
        end
        bus.res_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            samp();
            check("rot_ready", 32'(bus.req_ready), (c % 3 == 0) ? 32'(4'(1) << (c / 3)) : 32'd0);
            check("rot_valid", 32'(bus.res_valid), (c % 3 == 2) ? 32'd1 : 32'd0);
            if (c % 3 == 2) begin
                check("rot_id", 32'(bus.res_id), 32'(c / 3));
                check("rot_prod", 32'(bus.res_prod), 32'd1);
            end
            tick();
        end
        bus.req_valid = '0;
        drain();

        // Back-pressure with other requests pending.
        do_reset();
        bus.req_valid = 4'b0001;
        bus.req_a[0]  = 4'd3;
        bus.req_b[0]  = 5'b11110;
        samp();
        check("bp_grant0", 32'(bus.req_ready), 32'b0001);
        tick();
        bus.req_valid = 4'b1110;
        samp();
        check("bp_mul_ready", 32'(bus.req_ready), 32'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            samp();
            check("bp_hold_valid", 32'(bus.res_valid), 32'd1);
            check("bp_hold_prod", 32'(bus.res_prod), 32'h1FA);
            check("bp_hold_id", 32'(bus.res_id), 32'd0);
            check("bp_hold_ready", 32'(bus.req_ready), 32'd0);
            tick();
        end
        bus.res_ready = 1'b1;
        samp();
        check("bp_last_hold", 32'(bus.res_valid), 32'd1);
        tick();
        samp();
        check("bp_next_grant", 32'(bus.req_ready), 32'b0010);
        tick();
        drain();

        // Wrap-around: grant 1, then 3 (ptr wraps to 0), then {0,3} -> 0 wins.
        do_reset();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0010;
        samp();
        check("wrap_g1", 32'(bus.req_ready), 32'b0010);
        tick();
        drain();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b1000;
        samp();
        check("wrap_g3", 32'(bus.req_ready), 32'b1000);
        tick();
        drain();
        bus.req_valid = 4'b1001;
        samp();
        check("wrap_g0", 32'(bus.req_ready), 32'b0001);
        tick();
        drain();

        // Reset one cycle after a grant (FSM in MUL).
        do_reset();
        bus.res_ready = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_a[2]  = 4'd5;
        bus.req_b[2]  = 5'd5;
        samp();
        check("rstmul_grant", 32'(bus.req_ready), 32'b0100);
        tick();
        bus.req_valid = '0;
        rst_n = 1'b0;
        #1;
        check("rstmul_valid_now", 32'(bus.res_valid), 32'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            samp();
            check("rstmul_no_result", 32'(bus.res_valid), 32'd0);
            tick();
        end
        bus.req_valid = 4'b1010;
        samp();
        check("rstmul_ptr0", 32'(bus.req_ready), 32'b0010);
        tick();
        drain();

        // Randomized traffic against a transaction-level model.
        do_reset();
        begin
            int           m_ptr;
            bit           m_busy;
            int           m_age;
            int           g;
            logic [R-1:0] exp_ready;
            logic         exp_valid;
            res_t         r;
            m_ptr  = 0;
            m_busy = 1'b0;
            m_age  = 0;
            exp_q.delete();
            for (int cyc = 0; cyc < 600; cyc++) begin
                @(posedge clk);
                #1;
                bus.req_valid = 4'($urandom_range(0, 15));
                for (int i = 0; i < R; i++) begin
                    bus.req_a[i] = 4'($urandom);
                    bus.req_b[i] = 5'($urandom);
                end
                bus.res_ready = ($urandom_range(0, 3) != 0);
                samp();
                g         = m_busy ? -1 : ref_pick(bus.req_valid, m_ptr);
                exp_ready = (g >= 0) ? (4'(1) << g) : '0;
                exp_valid = m_busy && (m_age >= 2);
                check("rnd_req_ready", 32'(bus.req_ready), 32'(exp_ready));
                check("rnd_res_valid", 32'(bus.res_valid), 32'(exp_valid));
                if (exp_valid && exp_q.size() > 0) begin
                    check("rnd_res_prod", 32'(bus.res_prod), 32'(exp_q[0].prod));
                    check("rnd_res_id", 32'(bus.res_id), 32'(exp_q[0].id));
                end
                if (g >= 0) begin
                    r.id   = g;
                    r.prod = ref_mul(bus.req_a[g], bus.req_b[g]);
                    exp_q.push_back(r);
                    m_ptr  = (g + 1) % R;
                    m_busy = 1'b1;
                    m_age  = 1;
                end else if (m_busy) begin
                    if (exp_valid && bus.res_ready) begin
                        void'(exp_q.pop_front());
                        m_busy = 1'b0;
                    end else begin
                        m_age++;
                    end
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
